scan_timer_display: RTL and testbench

SCAN_TIMER_DISPLAY -- requirements
Module: scan_timer_display

---
 rtl/scan_timer_display.sv | 221 ++++++++++++++++++++++
 tb/tb_scan_timer_display.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_timer_display.sv
// ---------------------------------------------------------------------------
// scan_timer_display
//   Up/down BCD counter (mm:ss, hh:mm:ss or plain decimal) driving a
//   multiplexed, active-low 7-segment display.
//
//   Ports
//     clock     : system clock, rising edge
//     reset     : asynchronous active-low reset
//     run       : prescaler enable
//     up_dn     : 1 = count up, 0 = count down
//     clear     : synchronous clear of count, prescaler and expired
//     load      : synchronous load of load_bcd (validated first)
//     load_bcd  : BCD load value, digit 0 in bits [3:0] (rightmost)
//     blank_lz  : blank leading zero digits
//     AN        : active-low one-hot digit anodes, AN[0] = rightmost
//     C         : active-low segments {g,f,e,d,c,b,a}
//     DP        : active-low decimal point
//     expired   : sticky, set when a down count ticks at zero
//     load_err  : one-cycle pulse when a load is rejected
// ---------------------------------------------------------------------------
module scan_timer_display #(
    parameter int NUM_DIGITS = 4,
    parameter int TIME_MODE  = 1,
    parameter int TICK_DIV   = 100_000_000,
    parameter int SCAN_DIV   = 200_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              C,
    output logic                    DP,
    output logic                    expired,
    output logic                    load_err
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    // Top digit pair counts hours 00..23
    localparam bit HOURS = (TIME_MODE == 1) && (NUM_DIGITS == 6);

    // Largest value digit i may take when counting up. The hours units digit
    // only reaches 3 once the hours tens digit is 2.
    function automatic logic [3:0] up_max(input int i, input logic [CW-1:0] v);
        if (TIME_MODE == 0)     return 4'd9;
        if (HOURS && i == 5)    return 4'd2;
        if (HOURS && i == 4)    return (v[CW-1 -: 4] == 4'd2) ? 4'd3 : 4'd9;
        if (i % 2 == 1)         return 4'd5;
        return 4'd9;
    endfunction

    // Value a digit takes when a borrow passes through it. Borrowing through
    // the hours units digit always leaves the tens at 0 or 1, so 9 is right.
    function automatic logic [3:0] dn_max(input int i);
        if (TIME_MODE == 0)     return 4'd9;
        if (i % 2 == 1)         return 4'd5;
        return 4'd9;
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == up_max(i, v)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Only called with a non-zero count, so the borrow always resolves.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = dn_max(i);
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [CW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
            if (TIME_MODE == 1 && i % 2 == 1 && v[4*i +: 4] > 4'd5) ok = 1'b0;
        end
        if (HOURS && (v[CW-1 -: 4] > 4'd2 ||
                      (v[CW-1 -: 4] == 4'd2 && v[CW-5 -: 4] > 4'd3))) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    logic [CW-1:0]         count;
    logic [PW-1:0]         presc;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  zero_run;
    logic [3:0]            cur_digit;
    logic                  cur_blank;
    logic                  cur_dp_pos;
    logic                  tick;
    logic                  load_ok;

    assign tick    = run && (presc == PRESC_LAST);
    assign load_ok = bcd_valid(load_bcd);

    // Select the digit at the scan index and decide whether it is blanked:
    // a digit above 0 is blanked when it and everything to its left is zero.
    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (count[4*i +: 4] == 4'd0);
            blank_mask[i] = blank_lz && (i != 0) && zero_run;
        end
        cur_digit  = 4'd0;
        cur_blank  = 1'b0;
        cur_dp_pos = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                cur_digit  = count[4*i +: 4];
                cur_blank  = blank_mask[i];
                cur_dp_pos = (i == 2) || (i == 4);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            presc    <= '0;
            scan_cnt <= '0;
            scan_idx <= '0;
            expired  <= 1'b0;
            load_err <= 1'b0;
            AN       <= '1;
            C        <= 7'b1111111;
            DP       <= 1'b1;
        end else begin
            // Count path: clear beats load beats tick
            load_err <= 1'b0;
            if (clear) begin
                count   <= '0;
                presc   <= '0;
                expired <= 1'b0;
            end else if (load) begin
                if (load_ok) begin
                    count   <= load_bcd;
                    presc   <= '0;
                    expired <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (run) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    if (up_dn)            count   <= bcd_inc(count);
                    else if (count == '0) expired <= 1'b1;
                    else                  count   <= bcd_dec(count);
                end
            end

            // Scan path, free-running regardless of run
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            // Display registers, one cycle behind scan index and count
            AN <= cur_blank ? '1 : ~(NUM_DIGITS'(1) << scan_idx);
            C  <= cur_blank ? 7'b1111111 : seg7(cur_digit);
            DP <= !((TIME_MODE == 1) && !cur_blank && cur_dp_pos);
        end
    end

endmodule

// File: tb/tb_scan_timer_display.sv
// ---------------------------------------------------------------------------
// tb_scan_timer_display
//   Three instances share the control inputs: mm:ss (u4), 4-digit decimal
//   (u0) and hh:mm:ss (u6). A reference model keeps each count as a plain
//   integer (seconds or decimal value) and derives the expected display.
// ---------------------------------------------------------------------------
module tb_scan_timer_display;

    localparam int TD = 4;
    localparam int SD = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        run = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] ld4 = '0;
    logic [23:0] ld6 = '0;

    logic [3:0] an_a, an_b;
    logic [5:0] an_c;
    logic [6:0] c_a, c_b, c_c;
    logic       dp_a, dp_b, dp_c, ex_a, ex_b, ex_c, le_a, le_b, le_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    scan_timer_display #(.NUM_DIGITS(4), .TIME_MODE(1), .TICK_DIV(TD), .SCAN_DIV(SD)) u4 (
        .clock(clock), .reset(reset), .run(run), .up_dn(up_dn), .clear(clear), .load(load),
        .load_bcd(ld4), .blank_lz(blank_lz), .AN(an_a), .C(c_a), .DP(dp_a),
        .expired(ex_a), .load_err(le_a));
    scan_timer_display #(.NUM_DIGITS(4), .TIME_MODE(0), .TICK_DIV(TD), .SCAN_DIV(SD)) u0 (
        .clock(clock), .reset(reset), .run(run), .up_dn(up_dn), .clear(clear), .load(load),
        .load_bcd(ld4), .blank_lz(blank_lz), .AN(an_b), .C(c_b), .DP(dp_b),
        .expired(ex_b), .load_err(le_b));
    scan_timer_display #(.NUM_DIGITS(6), .TIME_MODE(1), .TICK_DIV(TD), .SCAN_DIV(SD)) u6 (
        .clock(clock), .reset(reset), .run(run), .up_dn(up_dn), .clear(clear), .load(load),
        .load_bcd(ld6), .blank_lz(blank_lz), .AN(an_c), .C(c_c), .DP(dp_c),
        .expired(ex_c), .load_err(le_c));

    logic [5:0] d_an[3];
    logic [6:0] d_c[3];
    logic       d_dp[3], d_ex[3], d_le[3];
    assign d_an[0] = {2'b11, an_a};
    assign d_an[1] = {2'b11, an_b};
    assign d_an[2] = an_c;
    assign d_c[0] = c_a;   assign d_c[1] = c_b;   assign d_c[2] = c_c;
    assign d_dp[0] = dp_a; assign d_dp[1] = dp_b; assign d_dp[2] = dp_c;
    assign d_ex[0] = ex_a; assign d_ex[1] = ex_b; assign d_ex[2] = ex_c;
    assign d_le[0] = le_a; assign d_le[1] = le_b; assign d_le[2] = le_c;

    // ---------------- reference model ----------------
    function automatic int nd_of(int k);  return (k == 2) ? 6 : 4;                          endfunction
    function automatic int tm_of(int k);  return (k == 1) ? 0 : 1;                          endfunction
    function automatic int mod_of(int k); return (k == 0) ? 3600 : ((k == 1) ? 10000 : 86400); endfunction

    function automatic int dig(int k, int v, int i);
        int d[6];
        int p;
        if (tm_of(k) == 1) begin
            d[0] = (v % 60) % 10;        d[1] = (v % 60) / 10;
            d[2] = ((v / 60) % 60) % 10; d[3] = ((v / 60) % 60) / 10;
            d[4] = (v / 3600) % 10;      d[5] = (v / 3600) / 10;
        end else begin
            p = v;
            for (int j = 0; j < 6; j++) begin d[j] = p % 10; p = p / 10; end
        end
        return d[i];
    endfunction

    function automatic int ldig(int k, int i);
        logic [23:0] w;
        w = (k == 2) ? ld6 : {8'h00, ld4};
        return int'(w[4*i +: 4]);
    endfunction

    function automatic bit load_ok(int k);
        bit ok = 1'b1;
        for (int i = 0; i < nd_of(k); i++) begin
            if (ldig(k, i) > 9) ok = 1'b0;
            if (tm_of(k) == 1 && i % 2 == 1 && ldig(k, i) > 5) ok = 1'b0;
        end
        if (k == 2 && ldig(k, 5) * 10 + ldig(k, 4) > 23) ok = 1'b0;
        return ok;
    endfunction

    function automatic int load_val(int k);
        int s = 0;
        int w = 1;
        if (tm_of(k) == 1)
            return (ldig(k,1)*10 + ldig(k,0)) + 60*(ldig(k,3)*10 + ldig(k,2))
                   + 3600*(ldig(k,5)*10 + ldig(k,4));
        for (int i = 0; i < nd_of(k); i++) begin s += ldig(k, i) * w; w *= 10; end
        return s;
    endfunction

    function automatic bit blanked(int k, int v, int ix);
        if (!blank_lz || ix == 0) return 1'b0;
        for (int j = ix; j < nd_of(k); j++) if (dig(k, v, j) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [6:0] seg_ref(int d);
        case (d)
            0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
            3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
            6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
            9: return 7'b0010000; default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] unseg(logic [6:0] c);
        for (int j = 0; j < 10; j++) if (seg_ref(j) == c) return 4'(j);
        return 4'hE;
    endfunction

    int         m_v[3], m_p[3], m_sc[3], m_ix[3];
    logic       m_ex[3], m_le[3], m_dp[3];
    logic [5:0] m_an[3];
    logic [6:0] m_c[3];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                m_v[k] <= 0; m_p[k] <= 0; m_sc[k] <= 0; m_ix[k] <= 0;
                m_ex[k] <= 1'b0; m_le[k] <= 1'b0; m_dp[k] <= 1'b1;
                m_an[k] <= 6'h3F; m_c[k] <= 7'h7F;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_an[k] <= blanked(k, m_v[k], m_ix[k]) ? 6'h3F : (6'h3F & ~(6'd1 << m_ix[k]));
                m_c[k]  <= blanked(k, m_v[k], m_ix[k]) ? 7'h7F : seg_ref(dig(k, m_v[k], m_ix[k]));
                m_dp[k] <= !(tm_of(k) == 1 && !blanked(k, m_v[k], m_ix[k]) &&
                             (m_ix[k] == 2 || m_ix[k] == 4));
                m_sc[k] <= (m_sc[k] == SD - 1) ? 0 : m_sc[k] + 1;
                m_ix[k] <= (m_sc[k] == SD - 1) ? (m_ix[k] + 1) % nd_of(k) : m_ix[k];
                m_le[k] <= !clear && load && !load_ok(k);
                if (clear) begin
                    m_v[k] <= 0; m_p[k] <= 0; m_ex[k] <= 1'b0;
                end else if (load) begin
                    if (load_ok(k)) begin m_v[k] <= load_val(k); m_p[k] <= 0; m_ex[k] <= 1'b0; end
                end else if (run) begin
                    if (m_p[k] == TD - 1) begin
                        m_p[k] <= 0;
                        if (up_dn)            m_v[k]  <= (m_v[k] + 1) % mod_of(k);
                        else if (m_v[k] == 0) m_ex[k] <= 1'b1;
                        else                  m_v[k]  <= m_v[k] - 1;
                    end else begin
                        m_p[k] <= m_p[k] + 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [23:0] cap_bcd;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_load(input logic [15:0] v4, input logic [23:0] v6);
        ld4 = v4; ld6 = v6; load = 1'b1; run = 1'b0;
        step();
        load = 1'b0;
    endtask

    // Prescaler is at 0 on entry, so four enabled edges produce one tick.
    task automatic tick_once();
        run = 1'b1;
        repeat (TD) step();
        run = 1'b0;
    endtask

    // Reads the shown digits of one instance back off the scanned display.
    task automatic capture(input int k);
        logic [3:0] dg[6];
        for (int i = 0; i < 6; i++) dg[i] = (i < nd_of(k)) ? 4'hF : 4'h0;
        repeat (2 * 6 * SD + 2) begin
            @(negedge clock);
            for (int i = 0; i < nd_of(k); i++)
                if (d_an[k] == (6'h3F & ~(6'd1 << i))) dg[i] = unseg(d_c[k]);
        end
        cap_bcd = {dg[5], dg[4], dg[3], dg[2], dg[1], dg[0]};
    endtask

    function automatic logic [23:0] rand_bcd(int nd);
        logic [23:0] r = '0;
        int d;
        if ($urandom_range(0, 3) == 0) begin r[3:0] = 4'($urandom_range(0, 3)); return r; end
        for (int i = 0; i < nd; i++) begin
            d = $urandom_range(0, 9);
            if (i % 2 == 1 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 5);
            if (i == 5 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) d = $urandom_range(10, 15);
            r[4*i +: 4] = 4'(d);
        end
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({d_an[k], d_c[k], d_dp[k], d_ex[k], d_le[k]} !== {6'h3F, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_hold dut%0d: AN=%b C=%b DP=%b exp=%b lerr=%b, need AN all 1 C=1111111 DP=1 exp=0 lerr=0",
                         k, d_an[k], d_c[k], d_dp[k], d_ex[k], d_le[k]);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({d_an[k], d_c[k], d_dp[k]} !== {6'h3E, 7'b1000000, 1'b1}) begin
                miscompares++;
                $display("FAIL reset_first_scan dut%0d: AN=%b C=%b DP=%b, need AN=111110 C=1000000 DP=1",
                         k, d_an[k], d_c[k], d_dp[k]);
            end
        end
    endtask

    task automatic test_time_carry();
        logic [23:0] want[3];
        up_dn = 1'b1; blank_lz = 1'b0;
        do_load(16'h0059, 24'h235959);
        tick_once();
        want[0] = 24'h000100; want[1] = 24'h000060; want[2] = 24'h000000;
        for (int k = 0; k < 3; k++) begin
            capture(k);
            vectors++;
            if (cap_bcd !== want[k]) begin
                miscompares++;
                $display("FAIL carry_59 dut%0d: shows %h, need %h", k, cap_bcd, want[k]);
            end
        end
        do_load(16'h5959, 24'h000059);
        tick_once();
        want[0] = 24'h000000; want[1] = 24'h005960; want[2] = 24'h000100;
        for (int k = 0; k < 3; k++) begin
            capture(k);
            vectors++;
            if (cap_bcd !== want[k] || d_ex[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL carry_wrap dut%0d: shows %h exp=%b, need %h exp=0", k, cap_bcd, d_ex[k], want[k]);
            end
        end
    endtask

    task automatic test_countdown();
        logic [23:0] want_b[3];
        logic        want_e[3];
        up_dn = 1'b0;
        do_load(16'h0002, 24'h000002);
        for (int t = 0; t < 3; t++) begin
            tick_once();
            for (int k = 0; k < 3; k++) begin
                want_b[k] = (t == 0) ? 24'h000001 : 24'h000000;
                want_e[k] = (t == 2);
                capture(k);
                vectors++;
                if (cap_bcd !== want_b[k] || d_ex[k] !== want_e[k]) begin
                    miscompares++;
                    $display("FAIL countdown_t%0d dut%0d: shows %h exp=%b, need %h exp=%b",
                             t, k, cap_bcd, d_ex[k], want_b[k], want_e[k]);
                end
            end
        end
        do_load(16'h0010, 24'h000010);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (d_ex[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL expired_cleared_by_load dut%0d: exp=%b, need 0", k, d_ex[k]);
            end
        end
        up_dn = 1'b1;
    endtask

    task automatic test_load_err();
        logic [23:0] want[3];
        ld4 = 16'h0070; ld6 = 24'h000070; load = 1'b1; run = 1'b0;
        step();
        load = 1'b0;
        vectors++;
        if ({d_le[0], d_le[1], d_le[2]} !== 3'b101) begin
            miscompares++;
            $display("FAIL load_err_pulse: lerr u4,u0,u6=%b%b%b, need 101", d_le[0], d_le[1], d_le[2]);
        end
        step();
        vectors++;
        if ({d_le[0], d_le[1], d_le[2]} !== 3'b000) begin
            miscompares++;
            $display("FAIL load_err_one_cycle: lerr u4,u0,u6=%b%b%b, need 000", d_le[0], d_le[1], d_le[2]);
        end
        want[0] = 24'h000010; want[1] = 24'h000070; want[2] = 24'h000010;
        for (int k = 0; k < 3; k++) begin
            capture(k);
            vectors++;
            if (cap_bcd !== want[k]) begin
                miscompares++;
                $display("FAIL load_reject_hold dut%0d: shows %h, need %h", k, cap_bcd, want[k]);
            end
        end
    endtask

    task automatic test_scan_blank();
        int n_on, n_off, n_other, n_badc, n_dp, n_dp0;
        do_load(16'h0005, 24'h000005);
        blank_lz = 1'b1;
        step();
        n_on = 0; n_off = 0; n_other = 0; n_badc = 0; n_dp = 0;
        for (int s = 0; s < 4 * 2 * SD; s++) begin
            step();
            if (an_a == 4'b1110) begin
                n_on++;
                if (c_a !== 7'b0010010) n_badc++;
            end else if (an_a == 4'b1111) begin
                n_off++;
                if (c_a !== 7'b1111111) n_badc++;
            end else n_other++;
            if (dp_a == 1'b0) n_dp++;
        end
        vectors++;
        if (n_on != 4 || n_off != 12 || n_other != 0 || n_badc != 0 || n_dp != 0) begin
            miscompares++;
            $display("FAIL blank_scan: AN=1110 x%0d, 1111 x%0d, other x%0d, bad C x%0d, DP low x%0d; need 4,12,0,0,0",
                     n_on, n_off, n_other, n_badc, n_dp);
        end
        blank_lz = 1'b0;
        step();
        n_dp = 0; n_dp0 = 0;
        for (int s = 0; s < 4 * 2 * SD; s++) begin
            step();
            if (dp_a == 1'b0) begin
                n_dp++;
                if (an_a !== 4'b1011) n_dp0 = n_dp0 + 100;
            end
            if (dp_b == 1'b0) n_dp0++;
        end
        vectors++;
        if (n_dp != 4 || n_dp0 != 0) begin
            miscompares++;
            $display("FAIL dp_scan: u4 DP low x%0d, misplaced/u0 DP code %0d; need 4 and 0", n_dp, n_dp0);
        end
    endtask

    task automatic test_priority();
        logic [23:0] want;
        up_dn = 1'b1;
        do_load(16'h0033, 24'h000033);
        run = 1'b1;
        repeat (TD - 1) step();
        clear = 1'b1; load = 1'b1; ld4 = 16'h0059; ld6 = 24'h000059;
        step();
        clear = 1'b0; load = 1'b0; run = 1'b0;
        vectors++;
        if ({d_le[0], d_le[1], d_le[2]} !== 3'b000) begin
            miscompares++;
            $display("FAIL clear_beats_load_err: lerr=%b%b%b, need 000", d_le[0], d_le[1], d_le[2]);
        end
        for (int k = 0; k < 3; k++) begin
            capture(k);
            vectors++;
            if (cap_bcd !== 24'h000000) begin
                miscompares++;
                $display("FAIL clear_priority dut%0d: shows %h, need 000000", k, cap_bcd);
            end
        end
        run = 1'b1;
        repeat (TD - 1) step();
        load = 1'b1; ld4 = 16'h0012; ld6 = 24'h000012;
        step();
        load = 1'b0; run = 1'b0;
        capture(0);
        vectors++;
        if (cap_bcd !== 24'h000012) begin
            miscompares++;
            $display("FAIL load_beats_tick: shows %h, need 000012", cap_bcd);
        end
        run = 1'b1; repeat (2) step();
        run = 1'b0; repeat (10) step();
        run = 1'b1; step();
        run = 1'b0;
        capture(0);
        vectors++;
        if (cap_bcd !== 24'h000012) begin
            miscompares++;
            $display("FAIL presc_hold_early: shows %h, need 000012", cap_bcd);
        end
        run = 1'b1; step();
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            want = (k == 1) ? 24'h000013 : 24'h000013;
            capture(k);
            vectors++;
            if (cap_bcd !== want) begin
                miscompares++;
                $display("FAIL presc_resume dut%0d: shows %h, need %h", k, cap_bcd, want);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_load(16'h1234, 24'h123456);
        run = 1'b1;
        repeat (13) step();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({d_an[k], d_c[k], d_dp[k], d_ex[k], d_le[k]} !== {6'h3F, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL mid_reset dut%0d: AN=%b C=%b DP=%b exp=%b lerr=%b, need all-off idle",
                         k, d_an[k], d_c[k], d_dp[k], d_ex[k], d_le[k]);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({d_an[k], d_c[k]} !== {6'h3E, 7'b1000000}) begin
                miscompares++;
                $display("FAIL mid_reset_restart dut%0d: AN=%b C=%b, need 111110 1000000", k, d_an[k], d_c[k]);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [23:0] r;
        for (int n = 0; n < 1500; n++) begin
            run   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            clear = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 11) == 0);
            r = rand_bcd(4); ld4 = r[15:0];
            ld6 = rand_bcd(6);
            step();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if ({d_an[k], d_c[k], d_dp[k], d_ex[k], d_le[k]} !==
                    {m_an[k], m_c[k], m_dp[k], m_ex[k], m_le[k]}) begin
                    miscompares++;
                    $display("FAIL random_c%0d dut%0d: AN=%b C=%b DP=%b exp=%b lerr=%b, model AN=%b C=%b DP=%b exp=%b lerr=%b",
                             n, k, d_an[k], d_c[k], d_dp[k], d_ex[k], d_le[k],
                             m_an[k], m_c[k], m_dp[k], m_ex[k], m_le[k]);
                end
            end
        end
        clear = 1'b0; load = 1'b0; run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_time_carry();
        test_countdown();
        test_load_err();
        test_scan_blank();
        test_priority();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
